g_2nor_in_filt: RTL
===================

Name: g_2nor_in_filt

Overview:
- Input-conditioning stage that sits directly upstream of the g_2nor schematic macro.
- Samples two raw asynchronous/noisy control inputs, optionally synchronises them, and debounces each with a persistence counter.
- Drives the cleaned levels A_F/B_F into an internal g_2nor instance, so YN is glitch-free and derived only from flops.
- Adds a one-cycle change strobe on YN for downstream event logic.

Parameters:
- FILT_CNT, default 4: consecutive samples a new input level must persist before it is accepted. Legal range 1..255; counter width is derived internally as clog2(FILT_CNT+1), minimum 1.

Ports:
- CLK, input, 1: single clock; all state updates on its rising edge.
- RSTN, input, 1: reset, asynchronous and active-low.
- CE, input, 1: clock enable; when low, all state freezes.
- A, input, 1: raw input A.
- B, input, 1: raw input B.
- A_F, output, 1: filtered level of A.
- B_F, output, 1: filtered level of B.
- YN, output, 1: NOR of A_F and B_F, produced by the g_2nor instance.
- CHG, output, 1: single-cycle strobe, high in the cycle YN takes a new value.

Behaviour:
- Reset (RSTN low, asynchronous):
  - sample/sync flops = 0, filtered flags = 0, counters = 0, CHG = 0.
  - Hence A_F = 0, B_F = 0, YN = 1.
  - Reset deassertion takes effect on the next CLK edge; no reset synchroniser inside.
- Per-channel filter (identical for A and B), evaluated on each CLK edge with CE = 1:
  - Sample stage: s <= input.
  - If s == f: cnt <= 0.
  - Else if cnt == FILT_CNT-1: f <= s, cnt <= 0.
  - Else: cnt <= cnt+1.
- Acceptance rules:
  - An input level held for >= FILT_CNT consecutive sampled cycles is accepted.
  - A level held for < FILT_CNT samples is rejected; the counter restarts on any return to f.
- Latency: an input change present before edge k appears on A_F/B_F after edge k+FILT_CNT, i.e. FILT_CNT+1 cycles (without the optional synchroniser).
- FILT_CNT = 1: one sample of disagreement is enough; latency is 2 cycles.
- Filter states, per channel, implicit in cnt:
  - STABLE: cnt == 0 and s == f.
  - PENDING: s != f. Exits to STABLE either on acceptance (f flips) or on abort (s returns to f).
- YN = ~(A_F | B_F), combinational from two flops through g_2nor. It is not separately registered.
- CHG is registered: CHG <= (next_YN != YN).
  - Both channels flipping on the same edge with no net YN change (e.g. A_F 1->0 and B_F 0->1): CHG stays 0.
  - Both rising on the same edge: exactly one CHG pulse.
- CE = 0:
  - Sample flops, counters and filtered flags all hold.
  - CHG is forced to 0 on that edge.
  - A pending count resumes where it stopped once CE returns high.
- Reset mid-PENDING: the count is discarded; after release the channel restarts from f = 0.
- No X-propagation requirement beyond reset; the raw inputs are allowed to be metastable-prone only when the optional synchroniser is compiled in.

Optional Feature:
- Macro G_2NOR_IN_FILT_SYNC_EN.
- Defined:
  - Each raw input passes through a 2-flop synchroniser ahead of the filter; the second flop replaces the single sample stage.
  - Both sync flops reset to 0 and obey CE.
  - Latency becomes FILT_CNT+2 cycles.
- Undefined:
  - Single sample flop; latency FILT_CNT+1.
  - Inputs must already be synchronous to CLK.

Decomposition:
- No package. FILT_CNT is a module parameter; counter width is a localparam computed with clog2.
- One natural sub-module, g_2nor_filt_ch (sample/sync, counter and filtered flag for one channel), instantiated twice.
- The existing g_2nor macro is instantiated once for YN; the NOR is not re-coded.

Test Plan:
- Reset: RSTN low with A = B = 1 -> A_F = 0, B_F = 0, YN = 1, CHG = 0 immediately, without waiting for CLK. Release, hold A = 1 -> A_F = 1 and YN = 0 exactly 5 cycles later (FILT_CNT = 4), with CHG = 1 for that one cycle.
- Glitch rejection, FILT_CNT = 4: A pulses high for 3 cycles -> A_F stays 0, YN stays 1, CHG never asserts. A 4-cycle pulse -> A_F rises at cycle 5 and falls 5 cycles after A falls.
- Chatter: A toggles 1,1,1,0,1,1,1,1 -> the counter aborts at the 0, and A_F rises only after the final 4-sample run.
- Simultaneous: A_F = 1, B_F = 0; drive A = 0 and B = 1 on the same cycle -> A_F and B_F swap on the same edge, YN stays 0, no CHG. Then drop B -> YN rises with one CHG.
- CE: start A's 0->1 transition, drop CE for 10 cycles after 2 samples -> no progress. Raise CE -> A_F rises after the 2 remaining samples.
- With G_2NOR_IN_FILT_SYNC_EN defined: repeat the first scenario -> latency is 6 cycles. Assert RSTN mid-PENDING -> A_F = 0 and the count restarts from zero after release.

Source files
------------

// File: rtl/g_2nor_in_filt_if.sv
`default_nettype none
// ============================================================================
// Module      : g_2nor_in_filt_if
// Description : Signal bundle for the g_2nor input-conditioning stage:
//               clock enable, the two raw inputs, the filtered levels,
//               the NOR result and its change strobe.
// Revision    : 1.0 - initial release
// ============================================================================
interface g_2nor_in_filt_if;
    logic CE;   // clock enable, state freezes when low
    logic A;    // raw input A
    logic B;    // raw input B
    logic A_F;  // filtered level of A
    logic B_F;  // filtered level of B
    logic YN;   // NOR of the filtered levels
    logic CHG;  // one-cycle strobe when YN changes

    // Stimulus / consumer side
    modport master (
        output CE, A, B,
        input  A_F, B_F, YN, CHG
    );

    // Filter side
    modport slave (
        input  CE, A, B,
        output A_F, B_F, YN, CHG
    );
endinterface
`default_nettype wire

// File: rtl/g_2nor.sv
`default_nettype none
// ============================================================================
// Module      : g_2nor
// Description : Two-input NOR schematic macro, YN = ~(A | B).
// Revision    : 1.0 - initial release
// ============================================================================
module g_2nor (
    input  wire logic A,
    input  wire logic B,
    output wire logic YN
);
    assign YN = ~(A | B);
endmodule
`default_nettype wire

// File: rtl/g_2nor_filt_ch.sv
`default_nettype none
// ============================================================================
// Module      : g_2nor_filt_ch
// Description : One debounce channel: sample (or 2-flop sync) stage followed
//               by a persistence counter that accepts a new level only after
//               FILT_CNT consecutive disagreeing samples.
//               Optional synchroniser: define G_2NOR_IN_FILT_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module g_2nor_filt_ch #(
    parameter int FILT_CNT = 4
) (
    input  wire logic clk_i,
    input  wire logic rst_n_i,
    input  wire logic ce_i,
    input  wire logic d_i,
    output wire logic f_o,    // accepted (filtered) level
    output wire logic f_d_o   // next-state of the filtered level
);
    localparam int CNT_W = ($clog2(FILT_CNT + 1) < 1) ? 1 : $clog2(FILT_CNT + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(FILT_CNT - 1);

    logic             s_q;
    logic             s_d;
    logic             f_q;
    logic             f_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

`ifdef G_2NOR_IN_FILT_SYNC_EN
    logic meta_q;

    // First synchroniser flop; the sample flop below acts as the second one
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
        end else if (ce_i) begin
            meta_q <= d_i;
        end
    end

    assign s_d = meta_q;
`else
    assign s_d = d_i;
`endif

    // Persistence counter: disagreement must survive FILT_CNT samples
    always_comb begin
        cnt_d = cnt_q;
        f_d   = f_q;
        if (s_q == f_q) begin
            cnt_d = '0;
        end else if (cnt_q == C_LAST) begin
            f_d   = s_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Sample flop, counter and filtered flag; all frozen while CE is low
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s_q   <= 1'b0;
            f_q   <= 1'b0;
            cnt_q <= '0;
        end else if (ce_i) begin
            s_q   <= s_d;
            f_q   <= f_d;
            cnt_q <= cnt_d;
        end
    end

    assign f_o   = f_q;
    assign f_d_o = f_d;
endmodule
`default_nettype wire

// File: rtl/g_2nor_in_filt.sv
`default_nettype none
// ============================================================================
// Module      : g_2nor_in_filt
// Description : Input-conditioning stage in front of the g_2nor macro. Both
//               raw inputs are debounced, the clean levels drive g_2nor, and
//               CHG pulses for one cycle whenever YN takes a new value.
//               Optional synchroniser: define G_2NOR_IN_FILT_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module g_2nor_in_filt #(
    parameter int FILT_CNT = 4
) (
    input wire logic          CLK,
    input wire logic          RSTN,
    g_2nor_in_filt_if.slave   bus
);
    logic a_f;
    logic a_f_d;
    logic b_f;
    logic b_f_d;
    logic yn;
    logic chg_q;
    logic chg_d;

    g_2nor_filt_ch #(.FILT_CNT(FILT_CNT)) u_ch_a (
        .clk_i   (CLK),
        .rst_n_i (RSTN),
        .ce_i    (bus.CE),
        .d_i     (bus.A),
        .f_o     (a_f),
        .f_d_o   (a_f_d)
    );

    g_2nor_filt_ch #(.FILT_CNT(FILT_CNT)) u_ch_b (
        .clk_i   (CLK),
        .rst_n_i (RSTN),
        .ce_i    (bus.CE),
        .d_i     (bus.B),
        .f_o     (b_f),
        .f_d_o   (b_f_d)
    );

    g_2nor u_nor (
        .A  (a_f),
        .B  (b_f),
        .YN (yn)
    );

    // YN changes exactly when the OR of the filtered flags changes, so a
    // swap of A_F/B_F on one edge yields no strobe; CE low forces it off
    always_comb begin
        chg_d = bus.CE & ((a_f_d | b_f_d) ^ (a_f | b_f));
    end

    // Change strobe register, aligned with the edge that updates YN
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            chg_q <= 1'b0;
        end else begin
            chg_q <= chg_d;
        end
    end

    assign bus.A_F = a_f;
    assign bus.B_F = b_f;
    assign bus.YN  = yn;
    assign bus.CHG = chg_q;
endmodule
`default_nettype wire
